// File: rtl/pixel_write_arbiter_if.sv
// Pixel-write arbitration bus: three packed requester job slots plus the
// shared vga_adapter pixel port and the grant/ack handshake.
interface pixel_write_arbiter_if #(
   parameter int LEN_W = 6
);
   logic [2:0]         req;
   logic [23:0]        req_x;
   logic [20:0]        req_y;
   logic [3*LEN_W-1:0] req_len;
   logic [26:0]        req_colour;
   logic [2:0]         grant;
   logic [2:0]         ack;
   logic               busy;
   logic [7:0]         x;
   logic [6:0]         y;
   logic [8:0]         colour;
   logic               plot;

   modport master (
      output req, req_x, req_y, req_len, req_colour,
      input  grant, ack, busy, x, y, colour, plot
   );

   modport slave (
      input  req, req_x, req_y, req_len, req_colour,
      output grant, ack, busy, x, y, colour, plot
   );
endinterface

// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter that streams one vertical-run job at a time onto the
// single vga_adapter pixel port, one pixel per clock, with a one-cycle ack.
module pixel_write_arbiter #(
   parameter int X_MAX = 160,
   parameter int Y_MAX = 120,
   parameter int LEN_W = 6
) (
   input logic                 clock,
   input logic                 resetn,
   pixel_write_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

   localparam logic [7:0] X_LIM = 8'(X_MAX);
   localparam logic [7:0] Y_LIM = 8'(Y_MAX);

   state_t             state_q, state_d;
   logic [1:0]         last_q, last_d;
   logic [1:0]         gidx_q, gidx_d;
   logic [7:0]         lx_q, lx_d;
   logic [6:0]         ly_q, ly_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [8:0]         lcol_q, lcol_d;
   logic [2:0]         grant_q, grant_d;
   logic [2:0]         ack_q, ack_d;
   logic               busy_q, busy_d;
   logic [7:0]         x_q, x_d;
   logic [6:0]         y_q, y_d;
   logic [8:0]         colour_q, colour_d;
   logic               plot_q, plot_d;

   logic [1:0]         pick, cand;
   logic               found;
   logic [7:0]         row_sum;

   // Search upward from the last winner so the most recent owner goes last.
   always_comb begin
      pick  = 2'd0;
      cand  = 2'd0;
      found = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         cand = 2'((int'(last_q) + k) % 3);
         if (!found && bus.req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // Eight bits so rows past 127 still compare as off-screen before the wrap.
   assign row_sum = {1'b0, ly_q} + 8'(cnt_q);

   always_comb begin
      // NOTE: every output of this block gets a default first; a path that
      // leaves one unassigned would infer a latch.
      state_d  = state_q;
      last_d   = last_q;
      gidx_d   = gidx_q;
      lx_d     = lx_q;
      ly_d     = ly_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      lcol_d   = lcol_q;
      grant_d  = grant_q;
      ack_d    = 3'b000;
      busy_d   = busy_q;
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
      plot_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               gidx_d  = pick;
               grant_d = 3'b001 << pick;
               busy_d  = 1'b1;
               lx_d    = bus.req_x[8*int'(pick) +: 8];
               ly_d    = bus.req_y[7*int'(pick) +: 7];
               len_d   = bus.req_len[LEN_W*int'(pick) +: LEN_W];
               lcol_d  = bus.req_colour[9*int'(pick) +: 9];
               cnt_d   = '0;
               state_d = (bus.req_len[LEN_W*int'(pick) +: LEN_W] != '0) ? DRAW : DONE;
            end
         end
         DRAW: begin
            x_d      = lx_q;
            y_d      = row_sum[6:0];
            colour_d = lcol_q;
            plot_d   = (lx_q < X_LIM) && (row_sum < Y_LIM);
            cnt_d    = cnt_q + LEN_W'(1);
            if (cnt_q == len_q - LEN_W'(1)) state_d = DONE;
         end
         DONE: begin
            ack_d   = grant_q;
            grant_d = 3'b000;
            busy_d  = 1'b0;
            last_d  = gidx_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, independent of statement order.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         last_q   <= 2'd2;
         gidx_q   <= 2'd0;
         lx_q     <= '0;
         ly_q     <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         lcol_q   <= '0;
         grant_q  <= '0;
         ack_q    <= '0;
         busy_q   <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
         plot_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         gidx_q   <= gidx_d;
         lx_q     <= lx_d;
         ly_q     <= ly_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         lcol_q   <= lcol_d;
         grant_q  <= grant_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
         plot_q   <= plot_d;
      end
   end

   assign bus.grant  = grant_q;
   assign bus.ack    = ack_q;
   assign bus.busy   = busy_q;
   assign bus.x      = x_q;
   assign bus.y      = y_q;
   assign bus.colour = colour_q;
   assign bus.plot   = plot_q;
endmodule
